pipe_hazard_unit: RTL and testbench
===================================

# pipe_hazard_unit

Parametrised hazard controller for the MIPS pipeline, replacing the fixed two-source, EX/MM/WB-only forwarding logic. It tracks destination registers for DEPTH stages after ID and produces per-port forwarding selects for the instruction in EX. It also generates load-use stalls and bubbles, IF/ID flushes on redirect, and a whole-pipe freeze on an external busy. It sits between the ID stage decode and the ID/EX, EX/MM and MM/WB pipeline registers.

## Interface
- REG_AW, 5, register address width
- NPORT, 2, source read ports per instruction
- DEPTH, 3, tracked stages after ID (1 = EX, 2 = MM, 3 = WB)
- LOAD_FWD, 3, lowest stage from which load data may be forwarded (2 ≤ LOAD_FWD ≤ DEPTH)
- CNT_W, 16, width of the event counters
- SELW, $clog2(DEPTH+1), derived width of each forwarding select

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  valid instruction in ID
- id_rs  in  NPORT*REG_AW  source addresses; port p at [p*REG_AW +: REG_AW]
- id_rs_used  in  NPORT  port p actually reads its register
- id_rd  in  REG_AW  destination of the ID instruction
- id_we  in  1  ID instruction writes the register file
- id_load  in  1  ID instruction is a load
- redirect  in  1  jump or taken branch resolved in ID this cycle
- mem_busy  in  1  external stall; freezes the whole pipe
- fwd_sel  out  NPORT*SELW  per EX operand: 0 = ID/EX operand, k = result of stage k (2..DEPTH)
- stall_if_id  out  1  hold PC and IF/ID
- bubble_ex  out  1  load NOP into ID/EX
- flush_if_id  out  1  clear IF/ID to NOP
- stage_we  out  DEPTH  valid-and-write flag per tracked stage (observability)
- stall_cnt  out  CNT_W  load-use bubbles inserted, saturating
- flush_cnt  out  CNT_W  flushes issued, saturating

## Operation
- State:
  - stage entry s = 1..DEPTH, holding {v, we, load, rd}.
  - EX source record {rs[NPORT], used[NPORT]} for the instruction in EX.
- Register file is write-first, so a WB producer reaching an ID consumer in the same cycle needs no tracking beyond DEPTH.
- Match(p, s): used[p] & entry[s].v & entry[s].we & entry[s].rd == rs[p] & rs[p] != 0. Register 0 never matches.
- fwd_sel[p] is combinational from the EX record. It is the smallest s in 2..DEPTH with Match, else 0. The nearest stage wins.
- Load-use hazard (lu):
  - id_valid & some port p & stage s with Match against the ID sources, entry[s].load, and s+1 < LOAD_FWD.
  - With defaults: a load in EX feeding the ID instruction.
- Priority per cycle (rst > mem_busy > lu > redirect):
  - mem_busy: stall_if_id=1, bubble_ex=0, flush_if_id=0. All state holds; counters hold.
  - lu: stall_if_id=1, bubble_ex=1, flush_if_id=0.
    - Entry 1 loads invalid; the EX record clears used.
    - Entries shift 1→2→…→DEPTH.
    - stall_cnt +1.
    - A simultaneous redirect is ignored; the branch re-presents after the stall.
  - redirect (no lu): flush_if_id=1, flush_cnt +1, normal advance.
  - normal:
    - Entries shift; entry DEPTH drops.
    - Entry 1 ← {id_valid, id_we, id_load, id_rd}.
    - EX record ← {id_rs, id_rs_used & {NPORT{id_valid}}}.
- Counters saturate at 2^CNT_W−1 and do not wrap.
- stage_we[s-1] = entry[s].v & entry[s].we.

## Timing
- All state updates occur on the rising clk edge.
- stall_if_id, bubble_ex, flush_if_id and fwd_sel are combinational and valid in the same cycle as their inputs.
- Reset: rst high at an edge clears all entries and the EX record to 0, and clears both counters.
  - While rst is high, all outputs are forced to 0.
  - Reset mid-stall drops the pending hazard; the first cycle after reset is a normal cycle.
- Load-use adds exactly one bubble per stage gap: LOAD_FWD−1−s cycles for a load at stage s. With defaults this is one cycle.
- During a stall, the ID consumer re-evaluates lu each cycle.
- Forwarding latency: a producer that leaves ID in cycle t is selectable as stage k in cycle t+k−1 by an EX consumer.
- mem_busy for N cycles delays every subsequent event by exactly N cycles; no entry is lost or duplicated.

## Test plan
- ALU chain: add r3 (ID, we) then sub reads r3 next cycle → in EX cycle fwd_sel[0]=2; one cycle later an independent reader of r3 gets fwd_sel=3; a reader of r0 gets 0.
- Load-use: lw r5 then add r6,r5,r1 → exactly one cycle with stall_if_id=1 and bubble_ex=1; add then sees fwd_sel[0]=3; stall_cnt=1.
- Double match: r4 written by stage-2 and stage-3 producers → fwd_sel=2 (nearest wins).
- Redirect during lu: redirect=1 with load-use the same cycle → flush_if_id=0, stall_if_id=1; next cycle redirect=1 alone → flush_if_id=1, flush_cnt=1.
- mem_busy for 3 cycles between a producer and a consumer → stage_we frozen for 3 cycles; forwarding afterwards is identical to the no-busy run, shifted 3 cycles.
- Reset mid-stall and counter saturation: rst during lu → all outputs 0 and entries cleared next cycle. With CNT_W=2, 5 load-use events → stall_cnt=3.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// Hazard controller: tracks destinations DEPTH stages past ID, selects EX
// forwarding sources, and raises load-use stalls, redirect flushes and busy freezes.
module pipe_hazard_unit #(
  parameter int REG_AW   = 5,
  parameter int NPORT    = 2,
  parameter int DEPTH    = 3,
  parameter int LOAD_FWD = 3,
  parameter int CNT_W    = 16,
  parameter int SELW     = $clog2(DEPTH+1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [NPORT*REG_AW-1:0] id_rs,
  input  logic [NPORT-1:0]        id_rs_used,
  input  logic [REG_AW-1:0]       id_rd,
  input  logic                    id_we,
  input  logic                    id_load,
  input  logic                    redirect,
  input  logic                    mem_busy,
  output logic [NPORT*SELW-1:0]   fwd_sel,
  output logic                    stall_if_id,
  output logic                    bubble_ex,
  output logic                    flush_if_id,
  output logic [DEPTH-1:0]        stage_we,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        flush_cnt
);

  // Index s-1 holds stage s (index 0 is the instruction in EX).
  logic [DEPTH-1:0]             r_v, r_we, r_ld;
  logic [DEPTH-1:0][REG_AW-1:0] r_rd;
  logic [NPORT-1:0][REG_AW-1:0] r_ex_rs;
  logic [NPORT-1:0]             r_ex_used;
  logic [CNT_W-1:0]             r_stall_cnt, r_flush_cnt;

  logic                         w_lu;
  logic [NPORT-1:0][SELW-1:0]   w_sel;
  logic [NPORT-1:0][REG_AW-1:0] w_id_rs;

  assign w_id_rs = id_rs;

  always_comb begin
    w_lu = 1'b0;
    for (int p = 0; p < NPORT; p++)
      for (int s = 0; s < DEPTH; s++)
        if (id_valid && id_rs_used[p] && r_v[s] && r_we[s] && r_ld[s] &&
            (r_rd[s] == w_id_rs[p]) && (w_id_rs[p] != '0) && (s + 2 < LOAD_FWD))
          w_lu = 1'b1;
  end

  // Scan from the oldest stage down so the nearest producer overrides.
  always_comb begin
    w_sel = '0;
    for (int p = 0; p < NPORT; p++)
      for (int s = DEPTH-1; s >= 1; s--)
        if (r_ex_used[p] && r_v[s] && r_we[s] && (r_rd[s] == r_ex_rs[p]) &&
            (r_ex_rs[p] != '0))
          w_sel[p] = SELW'(s + 1);
  end

  assign stall_if_id = !rst && (mem_busy || w_lu);
  assign bubble_ex   = !rst && !mem_busy && w_lu;
  assign flush_if_id = !rst && !mem_busy && !w_lu && redirect;
  assign fwd_sel     = rst ? '0 : w_sel;
  assign stage_we    = rst ? '0 : (r_v & r_we);
  assign stall_cnt   = rst ? '0 : r_stall_cnt;
  assign flush_cnt   = rst ? '0 : r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v         <= '0;
      r_we        <= '0;
      r_ld        <= '0;
      r_rd        <= '0;
      r_ex_rs     <= '0;
      r_ex_used   <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!mem_busy) begin
      for (int s = DEPTH-1; s >= 1; s--) begin
        r_v[s]  <= r_v[s-1];
        r_we[s] <= r_we[s-1];
        r_ld[s] <= r_ld[s-1];
        r_rd[s] <= r_rd[s-1];
      end
      r_v[0]  <= id_valid & ~w_lu;
      r_we[0] <= id_we    & ~w_lu;
      r_ld[0] <= id_load  & ~w_lu;
      r_rd[0] <= id_rd;
      if (w_lu) begin
        r_ex_used <= '0;
        if (~&r_stall_cnt) r_stall_cnt <= r_stall_cnt + 1'b1;
      end else begin
        r_ex_rs   <= w_id_rs;
        r_ex_used <= id_rs_used & {NPORT{id_valid}};
        if (redirect && ~&r_flush_cnt) r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Vector/scoreboard bench for pipe_hazard_unit: default build plus a CNT_W=2
// build driven in lockstep to exercise counter saturation.
module tb_pipe_hazard_unit;

  typedef struct {
    logic       rst, busy, redir, valid, we, load, chk_all;
    logic [4:0] rs0, rs1, rd;
    logic [1:0] used;
    logic [3:0] fwd;
    logic       stall, bub, flush;
    logic [2:0] swe;
    int         sc, fc;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, id_valid, id_we, id_load, redirect, mem_busy;
  logic [9:0] id_rs;
  logic [1:0] id_rs_used;
  logic [4:0] id_rd;

  logic [3:0]  a_fwd, b_fwd;
  logic        a_st, a_bb, a_fl, b_st, b_bb, b_fl;
  logic [2:0]  a_swe, b_swe;
  logic [15:0] a_sc, a_fc;
  logic [1:0]  b_sc, b_fc;

  pipe_hazard_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_we(id_we), .id_load(id_load), .redirect(redirect),
    .mem_busy(mem_busy), .fwd_sel(a_fwd), .stall_if_id(a_st), .bubble_ex(a_bb),
    .flush_if_id(a_fl), .stage_we(a_swe), .stall_cnt(a_sc), .flush_cnt(a_fc)
  );

  pipe_hazard_unit #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_we(id_we), .id_load(id_load), .redirect(redirect),
    .mem_busy(mem_busy), .fwd_sel(b_fwd), .stall_if_id(b_st), .bubble_ex(b_bb),
    .flush_if_id(b_fl), .stage_we(b_swe), .stall_cnt(b_sc), .flush_cnt(b_fc)
  );

  int   n_chk = 0, n_pass = 0, cyc = 0;
  vec_t sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(input logic r, bz, rdr, vl, input logic [4:0] a, b,
                              input logic [1:0] u, input logic [4:0] d, input logic w, l,
                              input logic [3:0] f, input logic st, bb, fl,
                              input logic [2:0] sw, input int sc, fc);
    vec_t x;
    x.rst = r; x.busy = bz; x.redir = rdr; x.valid = vl; x.rs0 = a; x.rs1 = b;
    x.used = u; x.rd = d; x.we = w; x.load = l; x.fwd = f; x.stall = st; x.bub = bb;
    x.flush = fl; x.swe = sw; x.sc = sc; x.fc = fc; x.chk_all = 1'b1;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
  endtask

  task automatic step(input vec_t x);
    vec_t e;
    int   sat;
    rst = x.rst; mem_busy = x.busy; redirect = x.redir; id_valid = x.valid;
    id_rs = {x.rs1, x.rs0}; id_rs_used = x.used; id_rd = x.rd;
    id_we = x.we; id_load = x.load;
    sb.push_back(x);
    @(negedge clk);
    e = sb.pop_front();
    sat = (e.sc > 3) ? 3 : e.sc;
    chk("stall_if_id", 32'(a_st), 32'(e.stall));
    chk("bubble_ex",   32'(a_bb), 32'(e.bub));
    chk("flush_if_id", 32'(a_fl), 32'(e.flush));
    chk("stall_cnt",   32'(a_sc), 32'(e.sc));
    chk("stall_cnt_sat", 32'(b_sc), 32'(sat));
    if (e.chk_all) begin
      chk("fwd_sel",   32'(a_fwd), 32'(e.fwd));
      chk("stage_we",  32'(a_swe), 32'(e.swe));
      chk("flush_cnt", 32'(a_fc), 32'(e.fc));
      chk("sat_outs", 32'({b_fwd, b_st, b_bb, b_fl, b_swe, b_fc}),
                      32'({e.fwd, e.stall, e.bub, e.flush, e.swe, 2'(e.fc)}));
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    vec_t v;
    int   sc;
    rst = 1'b1; mem_busy = 1'b0; redirect = 1'b0; id_valid = 1'b0;
    id_rs = '0; id_rs_used = '0; id_rd = '0; id_we = 1'b0; id_load = 1'b0;
    @(posedge clk); #1;

    // rst busy redir valid rs0 rs1 used rd we ld | fwd stall bub flush swe sc fc
    tbl.push_back(mk(1,0,0,1, 1,2,2'b11, 3,1,0, 4'b0000,0,0,0,3'b000,0,0)); // reset
    tbl.push_back(mk(0,0,0,1, 1,2,2'b11, 3,1,0, 4'b0000,0,0,0,3'b000,0,0)); // add r3
    tbl.push_back(mk(0,0,0,1, 3,4,2'b11, 7,1,0, 4'b0000,0,0,0,3'b001,0,0)); // sub r7,r3,r4
    tbl.push_back(mk(0,0,0,1, 0,3,2'b11, 8,1,0, 4'b0010,0,0,0,3'b011,0,0)); // or r8,r0,r3
    tbl.push_back(mk(0,0,0,0, 0,0,2'b00, 0,0,0, 4'b1100,0,0,0,3'b111,0,0));
    tbl.push_back(mk(0,0,0,1, 1,0,2'b01, 5,1,1, 4'b0000,0,0,0,3'b110,0,0)); // lw r5
    tbl.push_back(mk(0,0,1,1, 5,1,2'b11, 6,1,0, 4'b0000,1,1,0,3'b101,0,0)); // lu + redirect
    tbl.push_back(mk(0,0,1,1, 5,1,2'b11, 6,1,0, 4'b0000,0,0,1,3'b010,1,0)); // redirect alone
    tbl.push_back(mk(0,0,0,0, 0,0,2'b00, 0,0,0, 4'b0011,0,0,0,3'b101,1,1));
    tbl.push_back(mk(0,0,0,1, 0,0,2'b00, 4,1,0, 4'b0000,0,0,0,3'b010,1,1)); // A r4
    tbl.push_back(mk(0,0,0,1, 0,0,2'b00, 4,1,0, 4'b0000,0,0,0,3'b101,1,1)); // B r4
    tbl.push_back(mk(0,0,0,1, 4,4,2'b11, 9,0,0, 4'b0000,0,0,0,3'b011,1,1)); // reads r4,r4
    tbl.push_back(mk(0,0,0,0, 0,0,2'b00, 0,0,0, 4'b1010,0,0,0,3'b110,1,1)); // nearest wins
    tbl.push_back(mk(0,0,0,1, 0,0,2'b00,10,1,0, 4'b0000,0,0,0,3'b100,1,1)); // P r10
    for (int i = 0; i < 3; i++)                                            // busy x3
      tbl.push_back(mk(0,1,0,1,10,0,2'b01,11,1,0, 4'b0000,1,0,0,3'b001,1,1));
    tbl.push_back(mk(0,0,0,1,10,0,2'b01,11,1,0, 4'b0000,0,0,0,3'b001,1,1)); // Q reads r10
    tbl.push_back(mk(0,0,0,0, 0,0,2'b00, 0,0,0, 4'b0010,0,0,0,3'b011,1,1));
    tbl.push_back(mk(0,0,0,0, 0,0,2'b00, 0,0,0, 4'b0000,0,0,0,3'b110,1,1));
    foreach (tbl[i]) step(tbl[i]);

    // busy outranks load-use, then the load-use bubble lands once busy drops
    step(mk(0,0,0,1, 0,0,2'b00, 5,1,1, 4'b0000,0,0,0,3'b100,1,1));
    step(mk(0,1,0,1, 5,0,2'b01, 6,1,0, 4'b0000,1,0,0,3'b001,1,1));
    step(mk(0,0,0,1, 5,0,2'b01, 6,1,0, 4'b0000,1,1,0,3'b001,1,1));
    step(mk(0,0,0,1, 5,0,2'b01, 6,1,0, 4'b0000,0,0,0,3'b010,2,1));
    step(mk(0,0,0,0, 0,0,2'b00, 0,0,0, 4'b0011,0,0,0,3'b101,2,1));

    // five more load-use events; the 2-bit counter pins at 3
    sc = 2;
    for (int i = 0; i < 5; i++) begin
      v = mk(0,0,0,1, 0,0,2'b00, 5,1,1, 4'b0000,0,0,0,3'b000,sc,1); v.chk_all = 1'b0; step(v);
      v = mk(0,0,0,1, 5,0,2'b01, 6,1,0, 4'b0000,1,1,0,3'b000,sc,1); v.chk_all = 1'b0; step(v);
      sc++;
      v = mk(0,0,0,1, 5,0,2'b01, 6,1,0, 4'b0000,0,0,0,3'b000,sc,1); v.chk_all = 1'b0; step(v);
    end

    // reset lands on the load-use cycle
    v = mk(0,0,0,1, 0,0,2'b00, 5,1,1, 4'b0000,0,0,0,3'b000,sc,1); v.chk_all = 1'b0; step(v);
    step(mk(1,0,0,1, 5,0,2'b01, 6,1,0, 4'b0000,0,0,0,3'b000,0,0));
    step(mk(0,0,0,1, 5,0,2'b01, 6,1,0, 4'b0000,0,0,0,3'b000,0,0));
    step(mk(0,0,0,0, 0,0,2'b00, 0,0,0, 4'b0000,0,0,0,3'b001,0,0));

    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
